// File: rtl/nibble_serial_sub_if.sv
// Handshake and operand bus for the nibble-serial subtractor.
// The master drives a request; the slave (the subtractor) answers with status and result.
interface nibble_serial_sub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero
   );
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit CLA step per clock, LSB nibble first.
// Results are held in output registers that only change on the completing edge.
module nibble_serial_sub #(
   parameter int WIDTH = 16
) (
   input logic                 clk,
   input logic                 reset,
   nibble_serial_sub_if.slave  bus
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           stateQ, stateD;
   logic [WIDTH-1:0] aQ, aD;
   logic [WIDTH-1:0] bQ, bD;
   logic [WIDTH-1:0] partQ, partD;
   logic [WIDTH-1:0] diffQ, diffD;
   logic [CW-1:0]    cntQ, cntD;
   logic             carryQ, carryD;
   logic             boutQ, boutD;
   logic             zeroQ, zeroD;

   logic [3:0] x, y, p, g, sum;
   logic [4:0] c;
   logic       lastStep;

   // Subtraction as a + ~b + carry, carry seeded with ~bin on acceptance.
   always_comb begin
      x    = aQ[3:0];
      y    = ~bQ[3:0];
      p    = x ^ y;
      g    = x & y;
      c[0] = carryQ;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
   end

   assign lastStep = (cntQ == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (bus.start) stateD = RUN;
         RUN:     if (lastStep)  stateD = DONE;
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (stateQ == RUN);
      bus.done = (stateQ == DONE);
      bus.diff = diffQ;
      bus.bout = boutQ;
      bus.zero = zeroQ;
   end

   // Datapath next-state; the visible result is only loaded on the final step.
   always_comb begin
      aD     = aQ;
      bD     = bQ;
      partD  = partQ;
      diffD  = diffQ;
      cntD   = cntQ;
      carryD = carryQ;
      boutD  = boutQ;
      zeroD  = zeroQ;
      case (stateQ)
         IDLE: begin
            if (bus.start) begin
               aD     = bus.a;
               bD     = bus.b;
               carryD = ~bus.bin;
               cntD   = '0;
               partD  = '0;
            end
         end
         RUN: begin
            aD     = aQ >> 4;
            bD     = bQ >> 4;
            carryD = c[4];
            cntD   = cntQ + 1'b1;
            for (int k = 0; k < N; k++) begin
               if (cntQ == CW'(k)) partD[4*k +: 4] = sum;
            end
            if (lastStep) begin
               diffD = partD;
               boutD = ~c[4];
               zeroD = (partD == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aQ     <= '0;
         bQ     <= '0;
         partQ  <= '0;
         diffQ  <= '0;
         cntQ   <= '0;
         carryQ <= 1'b0;
         boutQ  <= 1'b0;
         zeroQ  <= 1'b1;
      end else begin
         aQ     <= aD;
         bQ     <= bD;
         partQ  <= partD;
         diffQ  <= diffD;
         cntQ   <= cntD;
         carryQ <= carryD;
         boutQ  <= boutD;
         zeroQ  <= zeroD;
      end
   end
endmodule
